// File: rtl/pcie_rx_pkg.sv
// Shared types, TLP type constants and helpers for the VC0 RX credit returner.
package pcie_rx_pkg;

  typedef enum logic [1:0] {CLS_POSTED, CLS_NONPOSTED, CLS_CPL, CLS_NONE} cls_e;
  typedef enum logic [1:0] {S_IDLE, S_HDR1, S_BODY} pst_e;
  typedef enum logic {P_IDLE, P_SPLIT} qst_e;

  // type[4:0] encodings; MWr/MRd share 00000 and differ only by fmt[1]
  localparam logic [4:0] T_MWR     = 5'b00000;
  localparam logic [4:0] T_MRD     = 5'b00000;
  localparam logic [4:0] T_MRDLK   = 5'b00001;
  localparam logic [4:0] T_IO      = 5'b00010;
  localparam logic [4:0] T_CFG0    = 5'b00100;
  localparam logic [4:0] T_CFG1    = 5'b00101;
  localparam logic [1:0] T_MSG_PFX = 2'b10;
  localparam logic [3:0] T_CPL_PFX = 4'b0101;

  localparam logic [8:0] CR_FULL  = 9'd256;
  localparam logic [7:0] CR_SPLIT = 8'd128;

  typedef struct packed {
    cls_e       cls;
    logic [8:0] cr;
    logic       auto_pop;
  } rec_t;

  function automatic cls_e classify(input logic hd, input logic [4:0] t);
    cls_e c;
    c = CLS_NONE;
    if ((t == T_MWR && hd) || t[4:3] == T_MSG_PFX)
      c = CLS_POSTED;
    else if (((t == T_MRD || t == T_MRDLK) && !hd) || t == T_IO ||
             t == T_CFG0 || t == T_CFG1)
      c = CLS_NONPOSTED;
    else if (t[4:1] == T_CPL_PFX)
      c = CLS_CPL;
    return c;
  endfunction

  // Data credits in 16-byte units; length 0 encodes 1024 DW.
  function automatic logic [8:0] data_cr(input logic hd, input logic [9:0] len);
    logic [10:0] l;
    l = (len == 10'd0) ? 11'd1024 : {1'b0, len};
    l = l + 11'd3;
    return hd ? l[10:2] : 9'd0;
  endfunction

endpackage

// File: rtl/pcie_rx_rec_fifo.sv
// Synchronous record FIFO; push while full is accepted only if a pop happens too.
module pcie_rx_rec_fifo
  import pcie_rx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  rec_t                     i_din,
  output rec_t                     o_dout,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  rec_t            r_mem [DEPTH];
  logic [AW-1:0]   r_wp, r_rp;
  logic [AW:0]     r_cnt;
  logic            w_do_push, w_do_pop;

  assign o_full    = (r_cnt == FULL_CNT);
  assign o_empty   = (r_cnt == '0);
  assign o_count   = r_cnt;
  assign o_dout    = r_mem[r_rp];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // storage write; contents need no reset since pointers gate visibility
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wp] <= i_din;
  end

  // pointers and occupancy
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wp <= r_wp + 1'b1;
      if (w_do_pop)  r_rp <= r_rp + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/pcie_rx_credit_return.sv
// Parses the VC0 RX TLP stream, queues one credit record per TLP and returns
// credits to the core as each TLP's buffer is released (or immediately if malformed).
module pcie_rx_credit_return
  import pcie_rx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   sys_clk_125,
  input  logic                   rst,
  input  logic [15:0]            rx_data_vc0,
  input  logic                   rx_st_vc0,
  input  logic                   rx_end_vc0,
  input  logic                   rx_malf_tlp_vc0,
  input  logic                   tlp_release,
  output logic                   ph_processed_vc0,
  output logic                   pd_processed_vc0,
  output logic                   nph_processed_vc0,
  output logic                   npd_processed_vc0,
  output logic                   cplh_processed_vc0,
  output logic                   cpld_processed_vc0,
  output logic [7:0]             pd_num_vc0,
  output logic [7:0]             npd_num_vc0,
  output logic [7:0]             cpld_num_vc0,
  output logic                   hdr_valid,
  output logic [6:0]             hdr_fmt_type,
  output logic [9:0]             hdr_len,
  output logic [$clog2(DEPTH):0] pend_cnt,
  output logic                   ovf_err
);
  pst_e        r_pst, w_pst_nxt;
  qst_e        r_qst, w_qst_nxt;
  logic [6:0]  r_ft, r_hdr_ft;
  logic [9:0]  r_len, r_hdr_len;
  logic        r_hdr_valid, r_ovf, r_pend;
  logic        w_push, w_pop, w_split, w_full, w_empty;
  rec_t        w_rec, w_head;
  logic [2:0]  w_oh, r_split_oh, r_hp, r_dp;
  logic [2:0][7:0] r_num;
  logic [7:0]  w_num;
  logic        w_unused;

  assign w_unused = rx_data_vc0[15];

  // parse state register
  always_ff @(posedge sys_clk_125) begin
    if (rst) r_pst <= S_IDLE;
    else     r_pst <= w_pst_nxt;
  end

  // parse next state; a new start always wins and abandons any TLP in flight
  always_comb begin
    w_pst_nxt = r_pst;
    w_push    = 1'b0;
    if (rx_st_vc0) begin
      w_pst_nxt = S_HDR1;
    end else begin
      case (r_pst)
        S_HDR1:  w_pst_nxt = S_BODY;
        S_BODY:  if (rx_end_vc0) begin
                   w_pst_nxt = S_IDLE;
                   w_push    = 1'b1;
                 end
        default: w_pst_nxt = r_pst;
      endcase
    end
  end

  // header field capture and completed-header reporting
  always_ff @(posedge sys_clk_125) begin
    if (rst) begin
      r_ft        <= '0;
      r_len       <= '0;
      r_hdr_valid <= 1'b0;
      r_hdr_ft    <= '0;
      r_hdr_len   <= '0;
    end else begin
      if (rx_st_vc0) r_ft <= rx_data_vc0[14:8];
      if (r_pst == S_HDR1 && !rx_st_vc0) r_len <= rx_data_vc0[9:0];
      r_hdr_valid <= w_push;
      if (w_push) begin
        r_hdr_ft  <= r_ft;
        r_hdr_len <= r_len;
      end
    end
  end

  always_comb begin
    w_rec.cls      = classify(r_ft[6], r_ft[4:0]);
    w_rec.cr       = data_cr(r_ft[6], r_len);
    w_rec.auto_pop = rx_malf_tlp_vc0;
  end

  pcie_rx_rec_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (sys_clk_125),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_rec),
    .o_dout  (w_head),
    .o_count (pend_cnt),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // sticky overflow when a record is lost
  always_ff @(posedge sys_clk_125) begin
    if (rst)                              r_ovf <= 1'b0;
    else if (w_push && w_full && !w_pop)  r_ovf <= 1'b1;
  end

  assign w_pop   = (r_qst == P_IDLE) && !w_empty &&
                   (w_head.auto_pop || tlp_release || r_pend);
  assign w_split = w_pop && (w_head.cls != CLS_NONE) && (w_head.cr == CR_FULL);
  assign w_num   = (w_head.cr == CR_FULL) ? CR_SPLIT : w_head.cr[7:0];

  // one-hot credit lane of the head record: 0 posted, 1 non-posted, 2 completion
  always_comb begin
    w_oh = 3'b000;
    case (w_head.cls)
      CLS_POSTED:    w_oh = 3'b001;
      CLS_NONPOSTED: w_oh = 3'b010;
      CLS_CPL:       w_oh = 3'b100;
      default:       w_oh = 3'b000;
    endcase
  end

  // pop state register
  always_ff @(posedge sys_clk_125) begin
    if (rst) r_qst <= P_IDLE;
    else     r_qst <= w_qst_nxt;
  end

  // pop next state; a 256-credit return needs a second 128-credit beat
  always_comb begin
    w_qst_nxt = r_qst;
    case (r_qst)
      P_IDLE:  if (w_split) w_qst_nxt = P_SPLIT;
      default: w_qst_nxt = P_IDLE;
    endcase
  end

  // credit pulses, split lane memory and release held during a split
  always_ff @(posedge sys_clk_125) begin
    if (rst) begin
      r_hp       <= '0;
      r_dp       <= '0;
      r_num      <= '0;
      r_split_oh <= '0;
      r_pend     <= 1'b0;
    end else begin
      r_hp  <= '0;
      r_dp  <= '0;
      r_num <= '0;
      if (r_qst == P_SPLIT) begin
        r_dp <= r_split_oh;
        for (int i = 0; i < 3; i++)
          if (r_split_oh[i]) r_num[i] <= CR_SPLIT;
      end else if (w_pop) begin
        r_hp       <= w_oh;
        r_split_oh <= w_oh;
        if (w_head.cr != 9'd0) begin
          r_dp <= w_oh;
          for (int i = 0; i < 3; i++)
            if (w_oh[i]) r_num[i] <= w_num;
        end
      end
      if (r_qst == P_SPLIT)            r_pend <= r_pend | tlp_release;
      else if (w_empty)                r_pend <= 1'b0;
      else if (w_pop && !w_head.auto_pop) r_pend <= r_pend & tlp_release;
      else                             r_pend <= r_pend | tlp_release;
    end
  end

  assign ph_processed_vc0   = r_hp[0];
  assign nph_processed_vc0  = r_hp[1];
  assign cplh_processed_vc0 = r_hp[2];
  assign pd_processed_vc0   = r_dp[0];
  assign npd_processed_vc0  = r_dp[1];
  assign cpld_processed_vc0 = r_dp[2];
  assign pd_num_vc0         = r_num[0];
  assign npd_num_vc0        = r_num[1];
  assign cpld_num_vc0       = r_num[2];
  assign hdr_valid          = r_hdr_valid;
  assign hdr_fmt_type       = r_hdr_ft;
  assign hdr_len            = r_hdr_len;
  assign ovf_err            = r_ovf;

endmodule
